// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared widths, FSM and stall-demand encodings for the hazard stall unit
package hazard_stall_unit_pkg;
  localparam int DEF_REG_W = 5;
  localparam int DEF_CNT_W = 32;
  localparam int ZERO_REG = 0;
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;
  typedef enum logic [1:0] {NEED_NONE = 2'd0, NEED_ONE = 2'd1, NEED_TWO = 2'd2} need_t;
endpackage

// File: rtl/hazard_stall_unit_detect.sv
// hazard_detect: combinational register-match logic producing the stall demand for the ID instruction
module hazard_detect
  import hazard_stall_unit_pkg::*;
#(
  parameter int W = DEF_REG_W
) (
  input  logic [W-1:0] rs_i,
  input  logic [W-1:0] rt_i,
  input  logic         uses_rt_i,
  input  logic         is_branch_i,
  input  logic [W-1:0] ex_rd_i,
  input  logic         ex_mem_read_i,
  input  logic         ex_reg_write_i,
  input  logic [W-1:0] mem_rd_i,
  input  logic         mem_mem_read_i,
  output need_t        need_o
);
  logic m_ex;
  logic m_mem;
  // $zero never creates a dependency; Rt only counts when the ID instruction reads it
  always_comb begin
    m_ex = (ex_rd_i != W'(ZERO_REG)) && ((rs_i == ex_rd_i) || (uses_rt_i && (rt_i == ex_rd_i)));
    m_mem = (mem_rd_i != W'(ZERO_REG)) && ((rs_i == mem_rd_i) || (uses_rt_i && (rt_i == mem_rd_i)));
    need_o = (is_branch_i && ex_mem_read_i && m_ex) ? NEED_TWO :
             (ex_mem_read_i && m_ex) ? NEED_ONE :
             (is_branch_i && ex_reg_write_i && !ex_mem_read_i && m_ex) ? NEED_ONE :
             (is_branch_i && mem_mem_read_i && m_mem) ? NEED_ONE : NEED_NONE;
  end
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / ID-branch stall and flush controller with saturating perf counters
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs,
  input  logic [REG_W-1:0] Rt,
  input  logic             id_usesRt,
  input  logic             id_isBranch,
  input  logic [REG_W-1:0] id_exRdDest,
  input  logic             id_exMemRead,
  input  logic             id_exRegWrite,
  input  logic [REG_W-1:0] ex_memRdOut,
  input  logic             ex_memMemRead,
  input  logic             branch_taken,
  input  logic             mem_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  need_t            need;
  logic             stall;
  logic             flush;

  hazard_detect #(.W(REG_W)) u_detect (
    .rs_i           (Rs),
    .rt_i           (Rt),
    .uses_rt_i      (id_usesRt),
    .is_branch_i    (id_isBranch),
    .ex_rd_i        (id_exRdDest),
    .ex_mem_read_i  (id_exMemRead),
    .ex_reg_write_i (id_exRegWrite),
    .mem_rd_i       (ex_memRdOut),
    .mem_mem_read_i (ex_memMemRead),
    .need_o         (need)
  );

  // state register; reset aborts any stall in progress
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // next state: HOLD ignores the hazard inputs and leaves once its remaining count runs out
  always_comb begin
    state_d = mem_stall ? state_q :
              (state_q == HOLD) ? ((rem_q <= 2'd1) ? RUN : HOLD) :
              (need == NEED_TWO) ? HOLD : RUN;
    rem_d   = mem_stall ? rem_q :
              (state_q == HOLD) ? rem_q - 2'd1 :
              (need == NEED_TWO) ? 2'd1 : rem_q;
  end

  // output decode: reset forces a bubble, a memory freeze silences everything
  always_comb begin
    stall        = (state_q == HOLD) || (need != NEED_NONE);
    flush        = rst && !mem_stall && !stall && branch_taken;
    pc_write     = rst && !mem_stall && !stall;
    if_id_write  = rst && !mem_stall && !stall;
    id_ex_bubble = !rst || (!mem_stall && stall);
    if_id_flush  = flush;
  end

  // saturating performance counters, frozen during a memory freeze
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!mem_stall) begin
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench for the hazard stall unit
module tb_hazard_stall_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs, Rt, id_exRdDest, ex_memRdOut;
  logic       id_usesRt, id_isBranch, id_exMemRead, id_exRegWrite, ex_memMemRead;
  logic       branch_taken, mem_stall;
  logic       pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic [3:0] stall_cnt, flush_cnt;

  typedef struct {
    string      nm;
    logic [3:0] o;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_sc = 0;
  int   exp_fc = 0;

  hazard_stall_unit #(.REG_W(5), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .Rs            (Rs),
    .Rt            (Rt),
    .id_usesRt     (id_usesRt),
    .id_isBranch   (id_isBranch),
    .id_exRdDest   (id_exRdDest),
    .id_exMemRead  (id_exMemRead),
    .id_exRegWrite (id_exRegWrite),
    .ex_memRdOut   (ex_memRdOut),
    .ex_memMemRead (ex_memMemRead),
    .branch_taken  (branch_taken),
    .mem_stall     (mem_stall),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .id_ex_bubble  (id_ex_bubble),
    .if_id_flush   (if_id_flush),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    Rs = 5'd1; Rt = 5'd1; id_exRdDest = 5'd0; ex_memRdOut = 5'd0;
    id_usesRt = 1'b0; id_isBranch = 1'b0; id_exMemRead = 1'b0; id_exRegWrite = 1'b0;
    ex_memMemRead = 1'b0; branch_taken = 1'b0; mem_stall = 1'b0;
  endtask

  // one pipeline cycle; o = {pc_write, if_id_write, id_ex_bubble, if_id_flush}
  task automatic cyc(input string nm, input logic [3:0] o);
    exp_t e;
    sb.push_back('{nm, o, 4'(exp_sc), 4'(exp_fc)});
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== e.o) begin
      n_bad++;
      $display("FAIL %s outputs: got %b want %b", e.nm,
               {pc_write, if_id_write, id_ex_bubble, if_id_flush}, e.o);
    end
    n_cmp++;
    if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
      n_bad++;
      $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
               e.nm, stall_cnt, flush_cnt, e.sc, e.fc);
    end
    if (!rst) begin
      exp_sc = 0;
      exp_fc = 0;
    end else if (!mem_stall) begin
      if (o[1]) exp_sc = (exp_sc == 15) ? 15 : exp_sc + 1;
      if (o[0]) exp_fc = (exp_fc == 15) ? 15 : exp_fc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b0;
    cyc("reset", 4'b0010);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    cyc("reset_release", 4'b1100);
  endtask

  task automatic test_load_use();
    do_reset();
    id_exMemRead = 1'b1; id_exRdDest = 5'd2; Rs = 5'd2;
    cyc("lu_stall", 4'b0010);
    clear_in();
    cyc("lu_clean", 4'b1100);
  endtask

  task automatic test_branch_load();
    do_reset();
    id_isBranch = 1'b1; id_usesRt = 1'b1; Rt = 5'd3; id_exMemRead = 1'b1; id_exRdDest = 5'd3;
    cyc("bl_run", 4'b0010);
    clear_in();
    cyc("bl_hold", 4'b0010);
    cyc("bl_clean", 4'b1100);
  endtask

  task automatic test_branch_alu();
    do_reset();
    id_isBranch = 1'b1; Rs = 5'd4; id_exRegWrite = 1'b1; id_exRdDest = 5'd4; branch_taken = 1'b1;
    cyc("ba_stall", 4'b0010);
    id_exRegWrite = 1'b0; id_exRdDest = 5'd0;
    cyc("ba_flush", 4'b1101);
    clear_in();
    cyc("ba_clean", 4'b1100);
  endtask

  task automatic test_no_stall();
    do_reset();
    id_exMemRead = 1'b1; id_exRdDest = 5'd0; Rs = 5'd0;
    cyc("ns_zero", 4'b1100);
    Rs = 5'd1; Rt = 5'd5; id_exRdDest = 5'd5; id_usesRt = 1'b0;
    cyc("ns_rt_unused", 4'b1100);
    id_usesRt = 1'b1;
    cyc("ns_rt_used", 4'b0010);
    clear_in();
    id_isBranch = 1'b1; Rs = 5'd6; ex_memMemRead = 1'b1; ex_memRdOut = 5'd6;
    cyc("ns_mem_load_br", 4'b0010);
    id_isBranch = 1'b0;
    cyc("ns_mem_load_nobr", 4'b1100);
  endtask

  task automatic test_mem_stall();
    do_reset();
    id_isBranch = 1'b1; Rs = 5'd7; id_exMemRead = 1'b1; id_exRdDest = 5'd7;
    cyc("ms_enter", 4'b0010);
    clear_in();
    mem_stall = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) cyc("ms_frozen", 4'b0000);
    clear_in();
    cyc("ms_resume_hold", 4'b0010);
    cyc("ms_done", 4'b1100);
    id_exMemRead = 1'b1; id_exRdDest = 5'd2; Rs = 5'd2; mem_stall = 1'b1;
    cyc("ms_run_frozen", 4'b0000);
    clear_in();
    cyc("ms_run_after", 4'b1100);
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    id_isBranch = 1'b1; Rs = 5'd8; id_exMemRead = 1'b1; id_exRdDest = 5'd8;
    cyc("rh_enter", 4'b0010);
    clear_in();
    rst = 1'b0;
    cyc("rh_reset", 4'b0010);
    rst = 1'b1;
    cyc("rh_run", 4'b1100);
  endtask

  task automatic test_saturation();
    do_reset();
    id_exMemRead = 1'b1; id_exRdDest = 5'd9; Rs = 5'd9;
    for (int i = 0; i < 18; i++) cyc("sat_stall", 4'b0010);
    clear_in();
    branch_taken = 1'b1;
    for (int i = 0; i < 18; i++) cyc("sat_flush", 4'b1101);
    clear_in();
    cyc("sat_end", 4'b1100);
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_no_stall();
    test_mem_stall();
    test_reset_in_hold();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
